shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator for the execute stage. It takes one WIDTH-bit operand, a shift count and an operation code per transaction, and performs one log2 stage per clock: rotate-left, shift-left, rotate-right, logical-right or arithmetic-right. Operand and result both use a valid/ready handshake, so the block accepts one operation per cycle and stalls cleanly under backpressure. It replaces the fixed 16-bit combinational shift stages in the ALU datapath.

---
 rtl/shifter_pipe.sv | 131 +++++++++++++
 tb/tb_shifter_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one log2 shift stage per clock with valid/ready flow control.
// Ops: 0 ROL, 1 SLL, 2 ROR, 3 SRL, 4 SRA; 5-7 pass the operand through and flag out_err.
`timescale 1ns/1ps
module shifter_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_cnt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam logic [2:0] OpRol = 3'd0;
    localparam logic [2:0] OpSll = 3'd1;
    localparam logic [2:0] OpRor = 3'd2;
    localparam logic [2:0] OpSrl = 3'd3;
    localparam logic [2:0] OpSra = 3'd4;

    logic [CW-1:0]    valid_q, valid_d;
    logic [WIDTH-1:0] data_q [CW];
    logic [WIDTH-1:0] data_d [CW];
    logic [CW-1:0]    cnt_q  [CW];
    logic [CW-1:0]    cnt_d  [CW];
    logic [2:0]       op_q   [CW];
    logic [2:0]       op_d   [CW];
    logic [CW-1:0]    err_q, err_d;

    logic [CW-1:0]    ready;
    logic [CW-1:0]    src_valid;
    logic [WIDTH-1:0] src_data [CW];
    logic [CW-1:0]    src_cnt  [CW];
    logic [2:0]       src_op   [CW];
    logic [CW-1:0]    src_err;

    // Shift by a fixed amount; SRA fills from the current MSB so sign survives every stage.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [2:0]       op,
                                                     input int unsigned      sh);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (op)
            OpRol:   res = (d << sh) | (d >> (WIDTH - sh));
            OpSll:   res = d << sh;
            OpRor:   res = (d >> sh) | (d << (WIDTH - sh));
            OpSrl:   res = d >> sh;
            OpSra:   res = (d >> sh) | (d[WIDTH-1] ? ~(ones >> sh) : '0);
            default: res = d;
        endcase
        return res;
    endfunction

    // Stage k can load when it and every stage downstream is not blocked.
    always_comb begin
        logic [CW-1:0] mask;
        ready = '0;
        for (int unsigned k = 0; k < CW; k++) begin
            mask     = (CW'(1) << k) - CW'(1);
            ready[k] = out_ready || ((valid_q | mask) != '1);
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_cnt[0]   = in_cnt;
        src_op[0]    = in_op;
        src_err[0]   = (in_op > OpSra);
        for (int unsigned k = 1; k < CW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_cnt[k]   = cnt_q[k-1];
            src_op[k]    = op_q[k-1];
            src_err[k]   = err_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        for (int unsigned k = 0; k < CW; k++) begin
            if (ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = src_cnt[k][k] ? stage_shift(src_data[k], src_op[k], 32'd1 << k)
                                              : src_data[k];
                    cnt_d[k]  = src_cnt[k];
                    op_d[k]   = src_op[k];
                    err_d[k]  = src_err[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int unsigned k = 0; k < CW; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
                op_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int unsigned k = 0; k < CW; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    assign in_ready  = !rst || ready[0];
    assign out_valid = valid_q[CW-1];
    assign out_data  = data_q[CW-1];
    assign out_err   = err_q[CW-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and randomised checks of shifter_pipe at WIDTH=16 against a bit-serial shift model.
`timescale 1ns/1ps
module tb_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_cnt = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q [$];

    shifter_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Returns {err, data}, shifting one bit at a time.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] c,
                                          input logic [2:0] op);
        logic [15:0] r;
        r = d;
        if (op > 3'd4) return {1'b1, d};
        for (int i = 0; i < int'(c); i++) begin
            case (op)
                3'd0:    r = {r[14:0], r[15]};
                3'd1:    r = {r[14:0], 1'b0};
                3'd2:    r = {r[0], r[15:1]};
                3'd3:    r = {1'b0, r[15:1]};
                default: r = {r[15], r[15:1]};
            endcase
        end
        return {1'b0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
        if (out_valid !== 1'b0) n_bad++;
        n_cmp++; if (out_data !== 16'h0000) begin
            n_bad++; $display("FAIL rst_out_data: got %h want 0000", out_data);
        end
        n_cmp++; if (out_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_out_err: got %b want 0", out_err);
        end
        n_cmp++; if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_in_ready_during: got %b want 1", in_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_in_ready_after: got %b want 1", in_ready);
        end
        step();
    endtask

    task automatic test_single_op(input string name, input logic [15:0] d, input logic [3:0] c,
                                  input logic [2:0] op, input logic [15:0] want_d,
                                  input logic want_e);
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        in_cnt = c;
        in_op = op;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++; if (lat != 4) begin
            n_bad++; $display("FAIL %s_latency: got %0d want 4", name, lat);
        end
        n_cmp++; if (out_data !== want_d) begin
            n_bad++; $display("FAIL %s_data: got %h want %h", name, out_data, want_d);
        end
        n_cmp++; if (out_err !== want_e) begin
            n_bad++; $display("FAIL %s_err: got %b want %b", name, out_err, want_e);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_single: got out_valid %b want 0", name, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                in_data = 16'(32'hACE1 + c * 32'h2357);
                in_cnt = 4'(c);
                in_op = 3'(c % 6);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 16) begin
                n_cmp++; if (in_ready !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_cnt, in_op));
            n_cmp++; if (out_valid !== (c >= 4 && c < 20)) begin
                n_bad++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, out_valid,
                                  (c >= 4 && c < 20));
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_data} !== e) begin
                        n_bad++; $display("FAIL b2b_data c=%0d: got %h want %h", c,
                                          {out_err, out_data}, e);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] bd [6];
        logic [3:0]  bc [6];
        logic [2:0]  bo [6];
        logic [15:0] held;
        logic [16:0] e;
        int n_acc;
        int n_out;
        bd = '{16'h8001, 16'h00FF, 16'h1234, 16'h8000, 16'hC3C3, 16'h0F0F};
        bc = '{4'd1, 4'd8, 4'd4, 4'd15, 4'd5, 4'd2};
        bo = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        n_acc = 0;
        n_out = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data = bd[n_acc];
            in_cnt = bc[n_acc];
            in_op = bo[n_acc];
            #1;
            if (in_ready === 1'b1) begin
                exp_q.push_back(model(in_data, in_cnt, in_op));
                n_acc++;
            end
            step();
        end
        n_cmp++; if (n_acc != 4) begin
            n_bad++; $display("FAIL bp_accepted: got %0d want 4", n_acc);
        end
        n_cmp++; if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
        end
        n_cmp++; if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_out_valid_full: got %b want 1", out_valid);
        end
        held = out_data;
        step();
        step();
        n_cmp++; if (out_data !== held) begin
            n_bad++; $display("FAIL bp_hold: got %h want %h", out_data, held);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            in_valid = (n_acc < 6);
            if (n_acc < 6) begin
                in_data = bd[n_acc];
                in_cnt = bc[n_acc];
                in_op = bo[n_acc];
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_cnt, in_op));
                n_acc++;
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                n_out++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_data} !== e) begin
                        n_bad++; $display("FAIL bp_data #%0d: got %h want %h", n_out,
                                          {out_err, out_data}, e);
                    end
                end
            end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (n_out != 6 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL bp_complete: got %0d outputs, %0d left want 6, 0", n_out,
                              exp_q.size());
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_no_dup: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        int sent;
        int got;
        logic pending;
        logic stalled;
        logic [16:0] held;
        logic [16:0] e;
        sent = 0;
        got = 0;
        pending = 1'b0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 8000 && got < 1000; c++) begin
            if (!pending && sent < 1000) begin
                in_data = 16'($urandom);
                in_cnt = 4'($urandom_range(0, 15));
                in_op = 3'($urandom_range(0, 7));
                pending = 1'b1;
            end
            in_valid = pending;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {out_err, out_data} !== held) begin
                    n_bad++; $display("FAIL rnd_stable c=%0d: got %b/%h want 1/%h", c,
                                      out_valid, {out_err, out_data}, held);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_cnt, in_op));
                sent++;
                pending = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                got++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_data} !== e) begin
                        n_bad++; $display("FAIL rnd_data #%0d: got %h want %h", got,
                                          {out_err, out_data}, e);
                    end
                end
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held = {out_err, out_data};
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (got != 1000) begin
            n_bad++; $display("FAIL rnd_count: got %0d want 1000", got);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data = 16'h1111 << c;
            in_cnt = 4'd3;
            in_op = 3'd0;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid);
        end
        n_cmp++; if (out_data !== 16'h0000) begin
            n_bad++; $display("FAIL mid_rst_data: got %h want 0000", out_data);
        end
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        n_cmp++; if (seen != 0) begin
            n_bad++; $display("FAIL mid_rst_ghost: got %0d results want 0", seen);
        end
        test_single_op("post_reset", 16'h00F0, 4'd2, 3'd1, 16'h03C0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_op("rol", 16'h8001, 4'd1, 3'd0, 16'h0003, 1'b0);
        test_single_op("sll", 16'h00FF, 4'd8, 3'd1, 16'hFF00, 1'b0);
        test_single_op("ror", 16'h1234, 4'd4, 3'd2, 16'h4123, 1'b0);
        test_single_op("ror_wrap", 16'h0001, 4'd15, 3'd2, 16'h0002, 1'b0);
        test_single_op("srl", 16'h8000, 4'd15, 3'd3, 16'h0001, 1'b0);
        test_single_op("sra_neg", 16'h8000, 4'd4, 3'd4, 16'hF800, 1'b0);
        test_single_op("sra_pos", 16'h7FFF, 4'd15, 3'd4, 16'h0000, 1'b0);
        test_single_op("cnt0", 16'hA5A5, 4'd0, 3'd3, 16'hA5A5, 1'b0);
        test_single_op("reserved", 16'h1234, 4'd3, 3'd7, 16'h1234, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
